// File: rtl/cmp_sort_ctrl_pkg.sv
// rtl/cmp_sort_ctrl_pkg.sv - shared constants and FSM encoding for the bubble-sort controller
package cmp_sort_ctrl_pkg;

   localparam int N_DEF = 8;
   localparam int W_DEF = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_LOAD = 2'd0;
   localparam state_t ST_SORT = 2'd1;
   localparam state_t ST_OUT  = 2'd2;

endpackage

// File: rtl/cmp_sort_ctrl_if.sv
// rtl/cmp_sort_ctrl_if.sv - load/unload handshake bundle for the sort controller
interface cmp_sort_ctrl_if
   import cmp_sort_ctrl_pkg::*;
#(
   parameter int W = W_DEF
);
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_desc;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;

   modport master (
      output in_valid, in_data, in_desc, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_desc, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/cmp_16b_str.sv
// rtl/cmp_16b_str.sv - structural 16-bit unsigned magnitude comparator (ripple from LSB)
module cmp_16b_str (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        a_is_greater,
   output logic        a_is_smaller
);
   genvar i;
   generate
      for (i = 0; i < 16; i++) begin : g_bit
         logic gt;
         logic lt;
         if (i == 0) begin : g_lsb
            assign gt = a[0] & ~b[0];
            assign lt = ~a[0] & b[0];
         end else begin : g_up
            // a higher differing bit overrides whatever the lower bits decided
            assign gt = (a[i] & ~b[i]) | (~(a[i] ^ b[i]) & g_bit[i-1].gt);
            assign lt = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & g_bit[i-1].lt);
         end
      end
   endgenerate

   assign a_is_greater = g_bit[15].gt;
   assign a_is_smaller = g_bit[15].lt;
endmodule

// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - load N words, bubble-sort in place with one comparator, stream them out
module cmp_sort_ctrl
   import cmp_sort_ctrl_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   cmp_sort_ctrl_if.slave  bus,
   output logic            busy,
   output logic [7:0]      swap_cnt
);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
   localparam logic [IW-1:0] IDX_PEN  = IW'(N - 2);

   state_t        state;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   logic [IW-1:0] j;
   logic [IW-1:0] j_nxt;
   logic [IW-1:0] pass;
   logic          pass_swapped;
   logic          desc;
   logic [W-1:0]  mem [N];
   logic [W-1:0]  a_word;
   logic [W-1:0]  b_word;
   logic          a_gt;
   logic          a_lt;
   logic          do_swap;
   logic          pass_end;
   logic          in_fire;
   logic          out_fire;

   assign bus.in_ready  = (state == ST_LOAD);
   assign bus.out_valid = (state == ST_OUT);
   assign bus.out_data  = mem[rd_idx];
   assign busy          = (state == ST_SORT);

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   assign j_nxt  = j + 1'b1;
   assign a_word = mem[j];
   assign b_word = mem[j_nxt];

   cmp_16b_str u_cmp (
      .a            (a_word),
      .b            (b_word),
      .a_is_greater (a_gt),
      .a_is_smaller (a_lt)
   );

   // strict compare in both directions keeps equal keys in arrival order
   assign do_swap  = (state == ST_SORT) && (desc ? a_lt : a_gt);
   assign pass_end = (j == (IDX_PEN - pass));

   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem[wr_idx] <= bus.in_data;
      end else if (do_swap) begin
         mem[j]     <= b_word;
         mem[j_nxt] <= a_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_LOAD;
         wr_idx       <= '0;
         rd_idx       <= '0;
         j            <= '0;
         pass         <= '0;
         pass_swapped <= 1'b0;
         swap_cnt     <= '0;
         desc         <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_fire) begin
                  wr_idx <= wr_idx + 1'b1;
                  if (wr_idx == '0) desc <= bus.in_desc;
                  if (wr_idx == IDX_LAST) begin
                     state        <= ST_SORT;
                     j            <= '0;
                     pass         <= '0;
                     pass_swapped <= 1'b0;
                     swap_cnt     <= '0;
                  end
               end
            end
            ST_SORT: begin
               if (do_swap && swap_cnt != 8'hFF) swap_cnt <= swap_cnt + 8'd1;
               if (pass_end) begin
                  // a clean pass means everything is already in order
                  if (!(pass_swapped || do_swap) || pass == IDX_PEN) begin
                     state <= ST_OUT;
                  end else begin
                     pass         <= pass + 1'b1;
                     j            <= '0;
                     pass_swapped <= 1'b0;
                  end
               end else begin
                  j            <= j_nxt;
                  pass_swapped <= pass_swapped | do_swap;
               end
            end
            ST_OUT: begin
               if (out_fire) begin
                  rd_idx <= rd_idx + 1'b1;
                  if (rd_idx == IDX_LAST) state <= ST_LOAD;
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb/tb_cmp_sort_ctrl.sv - randomized self-checking bench for cmp_sort_ctrl
module tb_cmp_sort_ctrl;
   import cmp_sort_ctrl_pkg::*;

   localparam int N = 8;
   localparam int W = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic [7:0] swap_cnt;

   always #5 clk = ~clk;

   cmp_sort_ctrl_if #(.W(W)) bus ();

   cmp_sort_ctrl #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .swap_cnt (swap_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] batch [N];
   logic [15:0] exp_q [N];
   int          exp_swaps;
   int          exp_cycles;
   int          sort_cycles;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bubble-sort facts: swaps = strict inversions; passes that swap = max count of
   // out-of-order elements to the left of any element; one extra clean pass unless capped.
   task automatic model(input bit desc);
      logic [15:0] v [N];
      logic [15:0] key;
      int          left, maxleft, passes, k;
      exp_swaps = 0;
      maxleft   = 0;
      for (int b = 0; b < N; b++) begin
         left = 0;
         for (int a = 0; a < b; a++)
            if (desc ? (batch[a] < batch[b]) : (batch[a] > batch[b])) left++;
         exp_swaps += left;
         if (left > maxleft) maxleft = left;
      end
      if (exp_swaps > 255) exp_swaps = 255;
      passes = (maxleft + 1 < N - 1) ? maxleft + 1 : N - 1;
      exp_cycles = 0;
      for (int p = 0; p < passes; p++) exp_cycles += N - 1 - p;
      for (int i = 0; i < N; i++) v[i] = batch[i];
      for (int i = 1; i < N; i++) begin
         key = v[i];
         k = i - 1;
         while (k >= 0 && (desc ? (key > v[k]) : (key < v[k]))) begin
            v[k+1] = v[k];
            k--;
         end
         v[k+1] = key;
      end
      for (int i = 0; i < N; i++) exp_q[i] = v[i];
   endtask

   task automatic load_batch(input bit desc, input bit gaps);
      for (int i = 0; i < N; ) begin
         @(negedge clk);
         check("load_ready", 32'(bus.in_ready), 32'd1);
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = batch[i];
            bus.in_desc  = (i == 0) ? desc : 1'($urandom);
            i++;
         end
      end
   endtask

   task automatic run_sort(input bit hold);
      @(negedge clk);
      check("busy_entry", 32'(busy), 32'd1);
      sort_cycles = 0;
      while (busy && sort_cycles < 200) begin
         sort_cycles++;
         bus.in_valid = hold;
         bus.in_data  = 16'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic run_out(input bit stall, input bit hold);
      int k = 0;
      int guard = 0;
      while (k < N && guard < 500) begin
         check("out_valid", 32'(bus.out_valid), 32'd1);
         check("out_data", 32'(bus.out_data), 32'(exp_q[k]));
         bus.out_ready = stall ? 1'($urandom) : 1'b1;
         bus.in_valid  = hold;
         bus.in_data   = 16'($urandom);
         @(posedge clk);
         if (bus.out_ready) k++;
         @(negedge clk);
         guard++;
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("out_count", 32'(k), 32'(N));
      check("back_to_load", 32'(bus.in_ready), 32'd1);
      check("out_valid_low", 32'(bus.out_valid), 32'd0);
      check("swap_cnt_hold", 32'(swap_cnt), 32'(exp_swaps));
   endtask

   task automatic do_batch(input bit desc, input bit gaps, input bit hold, input bit stall);
      model(desc);
      load_batch(desc, gaps);
      run_sort(hold);
      check("sort_cycles", 32'(sort_cycles), 32'(exp_cycles));
      check("swap_cnt", 32'(swap_cnt), 32'(exp_swaps));
      run_out(stall, hold);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_desc   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_swap_cnt", 32'(swap_cnt), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < N; i++) batch[i] = 16'(N - i);
      do_batch(1'b0, 1'b0, 1'b0, 1'b0);
      check("rev_cycles", 32'(sort_cycles), 32'd28);
      check("rev_swaps", 32'(swap_cnt), 32'd28);

      for (int i = 0; i < N; i++) batch[i] = 16'(i + 1);
      do_batch(1'b0, 1'b0, 1'b0, 1'b0);
      check("ord_cycles", 32'(sort_cycles), 32'd7);
      check("ord_swaps", 32'(swap_cnt), 32'd0);

      batch[0] = 16'h0005; batch[1] = 16'h0005; batch[2] = 16'hFFFF; batch[3] = 16'h0000;
      batch[4] = 16'h0005; batch[5] = 16'h0000; batch[6] = 16'hFFFF; batch[7] = 16'h0005;
      do_batch(1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < N; i++) batch[i] = 16'($urandom);
      do_batch(1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < N; i++) batch[i] = 16'(N - i);
      load_batch(1'b0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("busy_before_rst", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midsort_rst_ready", 32'(bus.in_ready), 32'd1);
      check("midsort_rst_busy", 32'(busy), 32'd0);
      check("midsort_rst_swaps", 32'(swap_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) batch[i] = 16'($urandom_range(0, 15));
      do_batch(1'b1, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 1000; t++) begin
         for (int i = 0; i < N; i++)
            batch[i] = (t % 2 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
         do_batch(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/cmp_sort_ctrl.md
CMP_SORT_CTRL -- requirements
Module: cmp_sort_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, number of entries (N >= 2, power of two).
REQ-002 SHALL have parameter W, default 16, unsigned data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, load word offered.
REQ-006 SHALL have port in_data, input, W, load word.
REQ-007 SHALL have port in_desc, input, 1, sort order (0 ascending, 1 descending), sampled with the first accepted word.
REQ-008 SHALL have port in_ready, output, 1, high only in LOAD.
REQ-009 SHALL have port out_valid, output, 1, high only in OUT.
REQ-010 SHALL have port out_data, output, W, current sorted word.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts word.
REQ-012 SHALL have port busy, output, 1, high in SORT.
REQ-013 SHALL have port swap_cnt, output, 8, swaps performed in the last sort (saturates at 255), stable from SORT exit until the next SORT entry.

Function
REQ-014 SHALL implement a three-state FSM: LOAD, SORT, OUT.
REQ-015 LOAD: each cycle with in_valid && in_ready SHALL write in_data to mem[wr_idx] and increment wr_idx; the Nth accept SHALL enter SORT next cycle.
REQ-016 SORT SHALL use exactly one comparator instance, evaluating one adjacent pair (mem[j], mem[j+1]) per cycle.
REQ-017 Swap condition SHALL be a_is_greater when ascending and a_is_smaller when descending; equal values SHALL never swap, so the sort is stable.
REQ-018 A swap SHALL take effect at the same clock edge as the compare, with no extra cycle.
REQ-019 Pass p (from 0) SHALL compare j = 0 .. N-2-p and SHALL take N-1-p cycles.
REQ-020 At the end of a pass, the FSM SHALL enter OUT if the pass made no swap or p = N-2; otherwise it SHALL start pass p+1 with j = 0.
REQ-021 Resulting SORT duration: N-1 cycles for already-ordered input; worst case N(N-1)/2 cycles (28 for N=8).
REQ-022 OUT: out_data SHALL equal mem[rd_idx] combinationally; each out_valid && out_ready SHALL increment rd_idx.
REQ-023 The Nth transfer SHALL return the FSM to LOAD next cycle with wr_idx = rd_idx = 0.
REQ-024 out_valid SHALL NOT drop, and out_data SHALL NOT change, while out_ready is low (backpressure holds indefinitely).
REQ-025 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside OUT.
REQ-026 swap_cnt SHALL clear on SORT entry and increment per swap.

Reset
REQ-027 rst_n low SHALL immediately force: state LOAD, wr_idx/rd_idx/j/pass = 0, swap_cnt = 0, desc = 0, in_ready = 1, out_valid = 0, busy = 0.
REQ-028 mem contents SHALL NOT be reset; out_data is don't-care while out_valid = 0.
REQ-029 Reset asserted mid-LOAD, mid-SORT or mid-OUT SHALL discard the partial batch; the next batch needs N fresh words.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (LOAD=0, SORT=1, OUT=2) and the default N/W constants.
REQ-031 The only sub-module SHALL be the existing 16-bit structural comparator cmp_16b_str, with W fixed to 16 when it is used.
REQ-032 Index widths SHALL be clog2(N) bits; wr_idx/rd_idx wrap-around SHALL coincide with the state change.

Verification
REQ-033 Load 8,7,6,5,4,3,2,1 ascending -> SORT lasts 28 cycles, swap_cnt = 28, output 1..8.
REQ-034 Load 1..8 ascending -> SORT lasts 7 cycles, swap_cnt = 0, output 1..8 unchanged.
REQ-035 Load 5,5,0xFFFF,0,5,0,0xFFFF,5 descending -> output FFFF,FFFF,5,5,5,5,0,0, with no swaps between equal values.
REQ-036 Random out_ready low (50%) during OUT -> out_data stable while stalled, exactly 8 transfers, then in_ready = 1.
REQ-037 rst_n pulsed low on SORT cycle 3 -> in_ready = 1 and busy = 0 without a clock edge; a new batch of 8 sorts correctly.
REQ-038 in_valid held high during SORT/OUT -> no data captured; mem/outputs match a golden model over 1000 random batches.
